// File: rtl/io_bus_arb2.sv
// Two-master round-robin arbiter onto a single 20-bit address / 8-bit data slave bus.
// One transaction is outstanding at a time, and a slave-ack timeout returns 0xFF read data.
module io_bus_arb2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [19:0] m0_address,
    input  logic [7:0]  m0_wdata,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic [7:0]  m0_rdata,
    output logic        m0_ack,
    input  logic [19:0] m1_address,
    input  logic [7:0]  m1_wdata,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic [7:0]  m1_rdata,
    output logic        m1_ack,
    output logic [19:0] s_address,
    output logic [7:0]  s_wdata,
    output logic        s_read,
    output logic        s_write,
    input  logic [7:0]  s_rdata,
    input  logic        s_ack,
    output logic        err_timeout,
    output logic        err_master
);

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          rr;
    logic          gnt;
    logic          op_wr;
    logic [CW-1:0] cnt;

    logic          rr_d;
    logic          gnt_d;
    logic          op_wr_d;
    logic [CW-1:0] cnt_d;
    logic [AW-1:0] s_address_d;
    logic [DW-1:0] s_wdata_d;
    logic          s_read_d;
    logic          s_write_d;
    logic [DW-1:0] m0_rdata_d;
    logic [DW-1:0] m1_rdata_d;
    logic          m0_ack_d;
    logic          m1_ack_d;
    logic          err_timeout_d;
    logic          err_master_d;

    logic req0_c;
    logic req1_c;
    logic sel_c;
    logic sel_wr_c;
    logic expire_c;

    assign req0_c   = m0_read | m0_write;
    assign req1_c   = m1_read | m1_write;
    // Contention goes to the pointer; a lone requester wins outright.
    assign sel_c    = (req0_c & req1_c) ? rr : req1_c;
    assign sel_wr_c = sel_c ? m1_write : m0_write;
    assign expire_c = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req0_c | req1_c) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (s_ack | expire_c) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next values for every registered output and datapath register.
    always_comb begin
        rr_d          = rr;
        gnt_d         = gnt;
        op_wr_d       = op_wr;
        cnt_d         = cnt;
        s_address_d   = s_address;
        s_wdata_d     = s_wdata;
        s_read_d      = 1'b0;
        s_write_d     = 1'b0;
        m0_rdata_d    = m0_rdata;
        m1_rdata_d    = m1_rdata;
        m0_ack_d      = 1'b0;
        m1_ack_d      = 1'b0;
        err_timeout_d = 1'b0;
        err_master_d  = err_master;

        case (state)
            ST_IDLE: begin
                if (req0_c | req1_c) begin
                    gnt_d       = sel_c;
                    rr_d        = ~sel_c;
                    op_wr_d     = sel_wr_c;
                    s_address_d = sel_c ? m1_address : m0_address;
                    s_wdata_d   = sel_c ? m1_wdata : m0_wdata;
                    s_write_d   = sel_wr_c;
                    s_read_d    = ~sel_wr_c;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
            end
            ST_WAIT: begin
                if (s_ack) begin
                    if (!op_wr) begin
                        if (gnt) m1_rdata_d = s_rdata;
                        else     m0_rdata_d = s_rdata;
                    end
                    m0_ack_d = ~gnt;
                    m1_ack_d = gnt;
                end else if (expire_c) begin
                    if (!op_wr) begin
                        if (gnt) m1_rdata_d = 8'hFF;
                        else     m0_rdata_d = 8'hFF;
                    end
                    m0_ack_d      = ~gnt;
                    m1_ack_d      = gnt;
                    err_timeout_d = 1'b1;
                    err_master_d  = gnt;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rr          <= 1'b0;
            gnt         <= 1'b0;
            op_wr       <= 1'b0;
            cnt         <= '0;
            s_address   <= '0;
            s_wdata     <= '0;
            s_read      <= 1'b0;
            s_write     <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            err_timeout <= 1'b0;
            err_master  <= 1'b0;
        end else begin
            rr          <= rr_d;
            gnt         <= gnt_d;
            op_wr       <= op_wr_d;
            cnt         <= cnt_d;
            s_address   <= s_address_d;
            s_wdata     <= s_wdata_d;
            s_read      <= s_read_d;
            s_write     <= s_write_d;
            m0_rdata    <= m0_rdata_d;
            m1_rdata    <= m1_rdata_d;
            m0_ack      <= m0_ack_d;
            m1_ack      <= m1_ack_d;
            err_timeout <= err_timeout_d;
            err_master  <= err_master_d;
        end
    end

endmodule

// File: tb/tb_io_bus_arb2.sv
// Directed bench for io_bus_arb2: outputs sampled 1ns after each rising edge,
// inputs driven at the same point so they are sampled on the following edge.
module tb_io_bus_arb2;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [19:0] m0_address, m1_address;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [7:0]  m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [19:0] s_address;
    logic [7:0]  s_wdata;
    logic        s_read, s_write;
    logic [7:0]  s_rdata;
    logic        s_ack;
    logic        err_timeout, err_master;

    int n_tests = 0;
    int n_fail  = 0;

    io_bus_arb2 #(.TIMEOUT(255)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_address(s_address), .s_wdata(s_wdata), .s_read(s_read), .s_write(s_write),
        .s_rdata(s_rdata), .s_ack(s_ack),
        .err_timeout(err_timeout), .err_master(err_master)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_address = '0; m1_address = '0; m0_wdata = '0; m1_wdata = '0;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        s_rdata = '0; s_ack = 0;
    endtask

    // Leaves the bench in the first IDLE cycle after reset release.
    task automatic do_reset();
        reset_reset_n = 0;
        clear_inputs();
        tick();
        tick();
        reset_reset_n = 1;
    endtask

    task automatic test_reset();
        reset_reset_n = 0;
        clear_inputs();
        tick();
        tick();
        n_tests++;
        if ({s_read, s_write, m0_ack, m1_ack, err_timeout, err_master} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 000000",
                {s_read, s_write, m0_ack, m1_ack, err_timeout, err_master});
        end
        n_tests++;
        if ({s_address, s_wdata, m0_rdata, m1_rdata} !== 44'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {s_address, s_wdata, m0_rdata, m1_rdata});
        end
        reset_reset_n = 1;
    endtask

    task automatic test_single_read();
        do_reset();
        m0_read = 1; m0_address = 20'h00123;
        tick();  // ISSUE
        n_tests++;
        if ({s_read, s_write} !== 2'b10 || s_address !== 20'h00123) begin
            n_fail++; $display("FAIL single_issue: rd/wr=%b addr=%h want 10 00123", {s_read, s_write}, s_address);
        end
        tick();  // WAIT, no ack yet
        n_tests++;
        if (s_read !== 0 || m0_ack !== 0) begin
            n_fail++; $display("FAIL single_pulse: s_read=%b m0_ack=%b want 0 0", s_read, m0_ack);
        end
        tick();
        s_ack = 1; s_rdata = 8'h5A;
        tick();  // DONE
        s_ack = 0; s_rdata = 8'h00;
        n_tests++;
        if (m0_ack !== 1 || m1_ack !== 0 || m0_rdata !== 8'h5A) begin
            n_fail++; $display("FAIL single_ack: m0_ack=%b m1_ack=%b rdata=%h want 1 0 5a", m0_ack, m1_ack, m0_rdata);
        end
        m0_read = 0;
        tick();
        n_tests++;
        if (m0_ack !== 0 || s_read !== 0) begin
            n_fail++; $display("FAIL single_after: m0_ack=%b s_read=%b want 0 0", m0_ack, s_read);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            m0_write = 1; m0_wdata = 8'h11; m0_address = 20'h000A0;
            m1_write = 1; m1_wdata = 8'h22; m1_address = 20'h000B0;
            tick();  // ISSUE for m0
            n_tests++;
            if (s_write !== 1 || s_read !== 0 || s_wdata !== 8'h11 || s_address !== 20'h000A0) begin
                n_fail++; $display("FAIL rr_first round %0d: wr=%b rd=%b wdata=%h addr=%h want 1 0 11 000a0",
                    r, s_write, s_read, s_wdata, s_address);
            end
            tick();
            s_ack = 1;
            tick();  // DONE for m0
            s_ack = 0;
            n_tests++;
            if (m0_ack !== 1 || m1_ack !== 0) begin
                n_fail++; $display("FAIL rr_ack0 round %0d: m0_ack=%b m1_ack=%b want 1 0", r, m0_ack, m1_ack);
            end
            m0_write = 0;
            tick();  // IDLE, m1 still waiting
            tick();  // ISSUE for m1
            n_tests++;
            if (s_write !== 1 || s_wdata !== 8'h22 || s_address !== 20'h000B0) begin
                n_fail++; $display("FAIL rr_second round %0d: wr=%b wdata=%h addr=%h want 1 22 000b0",
                    r, s_write, s_wdata, s_address);
            end
            tick();
            s_ack = 1;
            tick();  // DONE for m1
            s_ack = 0;
            n_tests++;
            if (m1_ack !== 1 || m0_ack !== 0 || m0_rdata !== 8'h00 || m1_rdata !== 8'h00) begin
                n_fail++; $display("FAIL rr_ack1 round %0d: m1_ack=%b m0_ack=%b rdata=%h/%h want 1 0 00/00",
                    r, m1_ack, m0_ack, m0_rdata, m1_rdata);
            end
            m1_write = 0;
            tick();
        end
    endtask

    task automatic test_timeout();
        logic early;
        early = 0;
        m1_read = 1; m1_address = 20'h55555;
        tick();  // ISSUE
        n_tests++;
        if (s_read !== 1 || s_address !== 20'h55555) begin
            n_fail++; $display("FAIL to_issue: s_read=%b addr=%h want 1 55555", s_read, s_address);
        end
        tick();  // first WAIT cycle
        for (int i = 0; i < 255; i++) begin
            if (i > 0) tick();
            if (err_timeout !== 0 || m1_ack !== 0) early = 1;
        end
        n_tests++;
        if (early !== 0) begin
            n_fail++; $display("FAIL to_early: timeout or ack before 255 wait cycles (got 1 want 0)");
        end
        tick();  // 255 cycles after WAIT entry
        n_tests++;
        if (err_timeout !== 1 || err_master !== 1 || m1_ack !== 1 || m1_rdata !== 8'hFF || m0_ack !== 0) begin
            n_fail++; $display("FAIL to_fire: err=%b master=%b m1_ack=%b rdata=%h m0_ack=%b want 1 1 1 ff 0",
                err_timeout, err_master, m1_ack, m1_rdata, m0_ack);
        end
        m1_read = 0;
        tick();
        n_tests++;
        if (err_timeout !== 0 || m1_ack !== 0) begin
            n_fail++; $display("FAIL to_pulse: err=%b m1_ack=%b want 0 0", err_timeout, m1_ack);
        end
        s_ack = 1; s_rdata = 8'h99;
        tick();
        s_ack = 0; s_rdata = 8'h00;
        tick();
        n_tests++;
        if (m1_rdata !== 8'hFF || m1_ack !== 0 || m0_ack !== 0 || s_read !== 0 || err_master !== 1) begin
            n_fail++; $display("FAIL to_late_ack: rdata=%h acks=%b%b s_read=%b master=%b want ff 00 0 1",
                m1_rdata, m0_ack, m1_ack, s_read, err_master);
        end
    endtask

    task automatic test_read_write_both();
        m0_read = 1; m0_write = 1; m0_wdata = 8'h3C; m0_address = 20'h00ABC;
        tick();  // ISSUE
        n_tests++;
        if (s_write !== 1 || s_read !== 0 || s_wdata !== 8'h3C || s_address !== 20'h00ABC) begin
            n_fail++; $display("FAIL rw_issue: wr=%b rd=%b wdata=%h addr=%h want 1 0 3c 00abc",
                s_write, s_read, s_wdata, s_address);
        end
        tick();
        s_ack = 1; s_rdata = 8'hEE;
        tick();  // DONE
        s_ack = 0; s_rdata = 8'h00;
        n_tests++;
        if (m0_ack !== 1 || m0_rdata !== 8'h00 || s_read !== 0) begin
            n_fail++; $display("FAIL rw_done: m0_ack=%b rdata=%h s_read=%b want 1 00 0", m0_ack, m0_rdata, s_read);
        end
        m0_read = 0; m0_write = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        m0_read = 1; m0_address = 20'h0F0F0;
        tick();  // ISSUE
        tick();  // WAIT
        tick();  // WAIT
        reset_reset_n = 0;
        m0_read = 0;
        #1;
        n_tests++;
        if ({s_address, s_wdata, s_read, s_write, m0_ack, m1_ack, err_timeout, err_master} !== 34'h0) begin
            n_fail++; $display("FAIL mid_async: addr=%h wdata=%h strobes=%b want 0",
                s_address, s_wdata, {s_read, s_write, m0_ack, m1_ack, err_timeout, err_master});
        end
        tick();
        tick();
        n_tests++;
        if (m0_ack !== 0 || m0_rdata !== 8'h00) begin
            n_fail++; $display("FAIL mid_noack: m0_ack=%b rdata=%h want 0 00", m0_ack, m0_rdata);
        end
        reset_reset_n = 1;
        m1_read = 1; m1_address = 20'h12345;
        tick();  // ISSUE
        n_tests++;
        if (s_read !== 1 || s_address !== 20'h12345) begin
            n_fail++; $display("FAIL mid_regrant: s_read=%b addr=%h want 1 12345", s_read, s_address);
        end
        tick();
        s_ack = 1; s_rdata = 8'h42;
        tick();  // DONE
        s_ack = 0; s_rdata = 8'h00;
        n_tests++;
        if (m1_ack !== 1 || m0_ack !== 0 || m1_rdata !== 8'h42) begin
            n_fail++; $display("FAIL mid_done: m1_ack=%b m0_ack=%b rdata=%h want 1 0 42", m1_ack, m0_ack, m1_rdata);
        end
        m1_read = 0;
        tick();
    endtask

    task automatic test_spurious_ack();
        s_ack = 1; s_rdata = 8'h77;
        tick();
        s_ack = 0; s_rdata = 8'h00;
        tick();
        n_tests++;
        if (m0_ack !== 0 || m1_ack !== 0 || s_read !== 0 || s_write !== 0) begin
            n_fail++; $display("FAIL spur_ack: acks=%b%b strobes=%b%b want 00 00", m0_ack, m1_ack, s_read, s_write);
        end
        n_tests++;
        if (m0_rdata !== 8'h00 || m1_rdata !== 8'h42) begin
            n_fail++; $display("FAIL spur_data: m0_rdata=%h m1_rdata=%h want 00 42", m0_rdata, m1_rdata);
        end
        m0_read = 1; m0_address = 20'h00777;
        tick();
        n_tests++;
        if (s_read !== 1 || s_address !== 20'h00777) begin
            n_fail++; $display("FAIL spur_idle: s_read=%b addr=%h want 1 00777", s_read, s_address);
        end
        m0_read = 0;
        tick();
        s_ack = 1; s_rdata = 8'h00;
        tick();
        s_ack = 0;
        tick();
    endtask

    initial begin
        clear_inputs();
        reset_reset_n = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_read_write_both();
        test_reset_mid();
        test_spurious_ack();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_arb2.md
IO_BUS_ARB2 -- requirements
Module: io_bus_arb2

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, slave-ack wait limit in clock cycles (1..255; 8-bit counter).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk_clk  in  1  sole clock; all state on rising edge.
REQ-004 reset_reset_n  in  1  asynchronous active-low reset.
REQ-005 m0_address/m1_address  in  20  master N address, stable while strobe high.
REQ-006 m0_wdata/m1_wdata  in  8  master N write data.
REQ-007 m0_read/m1_read, m0_write/m1_write  in  1 each  master N strobes, level, held until ack.
REQ-008 m0_rdata/m1_rdata  out  8  master N read data, registered.
REQ-009 m0_ack/m1_ack  out  1  master N completion, one-cycle pulse.
REQ-010 s_address  out  20; s_wdata  out  8  slave address/data, registered.
REQ-011 s_read/s_write  out  1  slave strobes, one-cycle pulses.
REQ-012 s_rdata  in  8; s_ack  in  1  slave read data, one-cycle ack.
REQ-013 err_timeout  out  1  one-cycle pulse on timeout; err_master  out  1  master index of last timeout.

Function
REQ-014 SHALL run FSM states IDLE, ISSUE, WAIT, DONE.
REQ-015 IDLE: request N = mN_read OR mN_write; none -> stay IDLE.
REQ-016 Single requester -> grant it; both -> grant master selected by rr pointer.
REQ-017 On grant: rr pointer = other master; latch address, wdata, op (write when mN_write=1, even if mN_read=1); go ISSUE.
REQ-018 ISSUE: s_write=1 (op write) or s_read=1 (op read) for exactly one cycle; s_address/s_wdata hold latched values; timeout counter cleared; go WAIT.
REQ-019 WAIT: s_ack=1 -> capture s_rdata (reads only), go DONE; else counter increments; counter reaches TIMEOUT -> err_timeout=1, err_master=granted index, read data = 0xFF, go DONE.
REQ-020 DONE: granted mN_ack=1 for one cycle; mN_rdata updated on read completion only, otherwise holds; next state IDLE.
REQ-021 Latency: request sampled in IDLE cycle n -> strobe in n+1; slave ack in cycle k (k>=n+2) -> master ack in k+1.
REQ-022 Masters SHALL drop strobe in cycle after ack; the DONE->IDLE cycle guarantees no duplicate grant.
REQ-023 s_ack in IDLE, ISSUE or DONE SHALL be ignored (no state change, no data capture); late ack after timeout is therefore discarded.
REQ-024 Non-granted master held off: its ack stays 0 and its strobe is serviced after current transaction, so no master waits more than one other transaction.
REQ-025 Only one slave transaction outstanding at any time; s_address/s_wdata hold value until next grant.

Reset
REQ-026 Reset asserted: FSM IDLE; rr pointer = m0; s_read, s_write, m0_ack, m1_ack, err_timeout = 0; s_address = 0; s_wdata, m0_rdata, m1_rdata = 0x00; err_master = 0; counter = 0.
REQ-027 Reset mid-transaction SHALL abandon it with no ack to any master; outputs reach reset values asynchronously.

Verification
REQ-028 m0 read 0x00123 alone, slave acks 2 cycles after s_read with 0x5A -> one s_read pulse, s_address=0x00123, m0_ack pulse one cycle after s_ack, m0_rdata=0x5A.
REQ-029 m0 and m1 write simultaneously from reset (m0 wdata 0x11, m1 0x22) -> m0 served first, then m1; s_wdata 0x11 then 0x22; repeat both -> m0 first again (pointer alternates).
REQ-030 m1 read, slave never acks, TIMEOUT=255 -> err_timeout pulse 255 cycles after WAIT entry, err_master=1, m1_rdata=0xFF, m1_ack pulse; later s_ack ignored.
REQ-031 Master asserts read and write together with wdata 0x3C -> s_write pulse only, s_wdata=0x3C, no s_read.
REQ-032 reset_reset_n low during WAIT of m0 read -> no m0_ack, all outputs reset; after release, new m1 request granted normally.
REQ-033 Spurious s_ack in IDLE with s_rdata=0x77 -> no ack, m0_rdata/m1_rdata unchanged.
